// File: rtl/add_pipe_32.sv
// add_pipe_32: two-stage pipelined 32-bit adder with a valid/ready handshake.
// Stage 1 adds the low 16-bit half and registers the carry into bit 16.
// Stage 2 adds the high half and registers sum, cout and signed overflow.
// Both halves use a 16-bit carry-lookahead adder built from 4-bit groups.
// Optional feature macro: ADDPIPE_SUB_EN adds the `sub` port (1 = a - b).
`timescale 1ns/1ps

module add_pipe_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
`ifdef ADDPIPE_SUB_EN
  input  logic        sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  // Returns {carry_out, sum[15:0]}. Four 4-bit groups: the group generate and
  // propagate terms produce the group carries, and each group ripples from
  // its own carry-in.
  function automatic logic [16:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [4:0]  gc;
    logic        gg;
    logic        gp;
    g     = x & y;
    p     = x ^ y;
    gc[0] = ci;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp = &p[4*k +: 4];
      gc[k+1] = gg | (gp & gc[k]);
      c[4*k]  = gc[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16] = gc[4];
    return {c[16], p ^ c[15:0]};
  endfunction

  logic        s1_valid;
  logic [15:0] s1_lo;
  logic        s1_c16;
  logic [15:0] s1_a_hi;
  logic [15:0] s1_b_hi;

  logic [31:0] b_eff;
  logic        c_eff;
  logic [16:0] lo_res;
  logic [16:0] hi_res;
  logic        s2_free;
  logic        accept;

  // Effective operands: with subtraction, b is inverted and the carry-in forced to 1.
  always_comb begin
`ifdef ADDPIPE_SUB_EN
    b_eff = sub ? ~b : b;
    c_eff = sub ? 1'b1 : cin;
`else
    b_eff = b;
    c_eff = cin;
`endif
  end

  // Low-half add for stage 1 and high-half add for stage 2.
  always_comb begin
    lo_res = cla16(a[15:0], b_eff[15:0], c_eff);
    hi_res = cla16(s1_a_hi, s1_b_hi, s1_c16);
  end

  // Handshake: stage 2 is free when empty or being consumed; no skid buffer,
  // so in_ready depends combinationally on out_ready.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    in_ready = !rst && (!s1_valid || s2_free);
    accept   = in_valid && in_ready;
  end

  // Stage 1: capture low-half sum, inter-half carry and raw high halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c16   <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_lo    <= lo_res[15:0];
      s1_c16   <= lo_res[16];
      s1_a_hi  <= a[31:16];
      s1_b_hi  <= b_eff[31:16];
    end else if (s1_valid && s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: finish the high half; results hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= {hi_res[15:0], s1_lo};
        cout <= hi_res[16];
        ovf  <= (s1_a_hi[15] == s1_b_hi[15]) && (hi_res[15] != s1_a_hi[15]);
      end
    end
  end

endmodule
